// File: rtl/wm8731_pkg.sv
// Shared WM8731 control-port definitions: responder states, device address, register map.
// With IIC_GLITCH_FILTER_EN defined, the input pipeline gains a 3-sample majority filter.
package wm8731_pkg;

  localparam int ADDR_W = 7;
  localparam int REG_W  = 7;
  localparam int VAL_W  = 9;
  localparam int WORD_W = REG_W + VAL_W;

  localparam logic [ADDR_W-1:0] WM8731_DEV_ADDR = 7'b0011010;

  localparam logic [REG_W-1:0] LLINE     = 7'd0;
  localparam logic [REG_W-1:0] RLINE     = 7'd1;
  localparam logic [REG_W-1:0] LHPOUT    = 7'd2;
  localparam logic [REG_W-1:0] RHPOUT    = 7'd3;
  localparam logic [REG_W-1:0] AAPATH    = 7'd4;
  localparam logic [REG_W-1:0] DAPATH    = 7'd5;
  localparam logic [REG_W-1:0] PDOWN     = 7'd6;
  localparam logic [REG_W-1:0] DAIF      = 7'd7;
  localparam logic [REG_W-1:0] SAMPLING  = 7'd8;
  localparam logic [REG_W-1:0] ACTIVE    = 7'd9;
  localparam logic [REG_W-1:0] RESET_REG = 7'd15;

`ifdef IIC_GLITCH_FILTER_EN
  localparam int EDGE_LAT = 5;
`else
  localparam int EDGE_LAT = 3;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK_1,
    ST_BYTE2, ST_ACK_2, ST_WAIT_STOP, ST_IGNORE
  } iic_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/wm8731_iic_responder_if.sv
// Bus-side signals of the WM8731 control-port responder: sampled I2C lines in, ACK drive and word out.
interface wm8731_iic_responder_if;
  import wm8731_pkg::*;

  logic              SCL_IN;
  logic              SDA_IN;
  logic              SDA_OE;
  logic [WORD_W-1:0] DATA;
  logic              VALID;
  logic              BUSY;
  logic              ERROR;

  modport slave  (input  SCL_IN, SDA_IN, output SDA_OE, DATA, VALID, BUSY, ERROR);
  modport master (output SCL_IN, SDA_IN, input  SDA_OE, DATA, VALID, BUSY, ERROR);
endinterface

// File: rtl/wm8731_iic_responder_line_sync.sv
// One I2C line: 2-flop synchronizer, optional majority filter (IIC_GLITCH_FILTER_EN), edge detect.
module iic_line_sync
  import wm8731_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       level;

  // NOTE: sequential state uses non-blocking assignments; resetting to 1 matches the idle-high bus so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], line_i};
  end

`ifdef IIC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= maj3(sync_q[1], hist_q[0], hist_q[1]);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= level;
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/wm8731_iic_responder.sv
// Write-only I2C target modelling the WM8731 control port: ACKs DEV_ADDR writes and
// presents each 16-bit {reg, value} word with a VALID strobe after STOP.
module wm8731_iic_responder
  import wm8731_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR = WM8731_DEV_ADDR,
  parameter int                MIN_HALF = 8
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  wm8731_iic_responder_if.slave bus
);

  // Edges reach the FSM EDGE_LAT cycles late; the master's half period must cover that.
  if (MIN_HALF <= EDGE_LAT) begin : g_min_half_check
    $error("MIN_HALF must exceed the input pipeline latency");
  end

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_sync u_scl_sync (
    .clk(MCLK), .rst_n(RESET), .line_i(bus.SCL_IN),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  iic_line_sync u_sda_sync (
    .clk(MCLK), .rst_n(RESET), .line_i(bus.SDA_IN),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  iic_state_e        state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic              byte_done_q;
  logic              err_pend_q;
  logic [WORD_W-1:0] stage_q;
  logic [WORD_W-1:0] data_q;
  logic              sda_oe_q, valid_q, busy_q, error_q;

  logic addr_ok, restart_err;
  assign addr_ok     = (shift_q == {DEV_ADDR, 1'b0});
  // A fresh address phase or a foreign transfer being ignored is not a broken write.
  assign restart_err = !(state_q inside {ST_IDLE, ST_ADDR}) &&
                       !(state_q == ST_IGNORE && !err_pend_q);

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      err_pend_q  <= 1'b0;
      stage_q     <= '0;
      data_q      <= '0;
      sda_oe_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (start_det) begin
        error_q     <= restart_err;
        state_q     <= ST_ADDR;
        busy_q      <= 1'b1;
        shift_q     <= '0;
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        err_pend_q  <= 1'b0;
        stage_q     <= '0;
        sda_oe_q    <= 1'b0;
      end else if (stop_det) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        sda_oe_q    <= 1'b0;
        err_pend_q  <= 1'b0;
        byte_done_q <= 1'b0;
        case (state_q)
          ST_IDLE:      ;
          ST_WAIT_STOP: begin
            data_q  <= stage_q;
            valid_q <= 1'b1;
          end
          ST_IGNORE:    error_q <= err_pend_q;
          default:      error_q <= 1'b1;
        endcase
      end else begin
        case (state_q)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              sda_oe_q    <= (state_q != ST_ADDR) || addr_ok;
              case (state_q)
                ST_ADDR:  state_q <= addr_ok ? ST_ACK_A : ST_IGNORE;
                ST_BYTE1: begin
                  stage_q[15:8] <= shift_q;
                  state_q       <= ST_ACK_1;
                end
                default: begin
                  stage_q[7:0] <= shift_q;
                  state_q      <= ST_ACK_2;
                end
              endcase
            end
          end
          ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              case (state_q)
                ST_ACK_A: state_q <= ST_BYTE1;
                ST_ACK_1: state_q <= ST_BYTE2;
                default:  state_q <= ST_WAIT_STOP;
              endcase
            end
          end
          // A completed SCL pulse here is an extra data bit; a STOP rises SDA before SCL falls.
          ST_WAIT_STOP: begin
            if (scl_fall) begin
              state_q    <= ST_IGNORE;
              err_pend_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.SDA_OE = sda_oe_q;
  assign bus.DATA   = data_q;
  assign bus.VALID  = valid_q;
  assign bus.BUSY   = busy_q;
  assign bus.ERROR  = error_q;

endmodule

// File: tb/tb_wm8731_iic_responder.sv
// Bench for wm8731_iic_responder: directed vector table, hand-written corner sequences,
// and random write transactions checked against a rule-level model of the control port.
module tb_wm8731_iic_responder;
  import wm8731_pkg::*;

  localparam int HALF = 10;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  wm8731_iic_responder_if bus();
  assign bus.SCL_IN = scl_m;
  assign bus.SDA_IN = sda_m & ~bus.SDA_OE;

  wm8731_iic_responder #(.DEV_ADDR(WM8731_DEV_ADDR), .MIN_HALF(8)) dut (
    .MCLK(mclk), .RESET(rst_n), .bus(bus)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic [15:0] ref_data = 16'h0000;

  always @(negedge mclk) begin
    if (bus.VALID) valid_cnt++;
    if (bus.ERROR) err_cnt++;
  end

  typedef struct {
    string           name;
    logic [7:0]      addr;
    int              nb;
    logic [2:0][7:0] bytes;
    logic [3:0]      exp_ack;
    int              exp_valid;
    int              exp_err;
    logic [15:0]     exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
  endtask

  task automatic send_bit(input logic b);
    cyc(HALF/2); sda_m = b;
    cyc(HALF/2); scl_m = 1'b1;
    cyc(HALF);   scl_m = 1'b0;
  endtask

  task automatic ack_bit(output logic a);
    cyc(HALF/2); sda_m = 1'b1;
    cyc(HALF/2); scl_m = 1'b1;
    cyc(HALF/2); #1 a = bus.SDA_OE;
    cyc(HALF/2); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_start();
    if (!scl_m) begin
      cyc(HALF/2); sda_m = 1'b1;
      cyc(HALF/2); scl_m = 1'b1;
      cyc(HALF);
    end
    sda_m = 1'b0;
    cyc(HALF); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    cyc(HALF/2); sda_m = 1'b0;
    cyc(HALF/2); scl_m = 1'b1;
    cyc(HALF);   sda_m = 1'b1;
    cyc(2*HALF);
  endtask

  task automatic run_txn(input vec_t v);
    logic       a;
    logic [3:0] acks;
    acks = '0;
    valid_cnt = 0;
    err_cnt   = 0;
    do_start();
    #1 check({v.name, "_busy_hi"}, bus.BUSY, 1);
    send_byte(v.addr);
    ack_bit(a); acks[0] = a;
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.bytes[i]);
      ack_bit(a); acks[i+1] = a;
    end
    do_stop();
    #1;
    check({v.name, "_ack"},   acks,      v.exp_ack);
    check({v.name, "_valid"}, valid_cnt, v.exp_valid);
    check({v.name, "_error"}, err_cnt,   v.exp_err);
    check({v.name, "_data"},  bus.DATA,  v.exp_data);
    check({v.name, "_busy_lo"}, bus.BUSY, 0);
  endtask

  // Control-port rules: only a write to the device address is acknowledged, exactly two
  // data bytes followed by STOP commit a word, anything else on an acknowledged write is an error.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_ack = '0; r.exp_valid = 0; r.exp_err = 0;
    if (v.addr == {WM8731_DEV_ADDR, 1'b0}) begin
      r.exp_ack[0] = 1'b1;
      for (int i = 0; i < v.nb && i < 2; i++) r.exp_ack[i+1] = 1'b1;
      if (v.nb == 2) begin
        r.exp_valid = 1;
        ref_data    = {v.bytes[0], v.bytes[1]};
      end else begin
        r.exp_err = 1;
      end
    end
    r.exp_data = ref_data;
    return r;
  endfunction

  vec_t table_v [5];
  vec_t v;
  logic a;
  logic [2:0] acks3;

  initial begin
    table_v[0] = '{"reset_word", 8'h34, 2, {8'h00, 8'h00, {RESET_REG, 1'b0}}, 4'b0111, 1, 0, 16'h1E00};
    table_v[1] = '{"wrong_addr", 8'h36, 2, {8'h00, 8'hAA, 8'h55},             4'b0000, 0, 0, 16'h1E00};
    table_v[2] = '{"read_bit",   8'h35, 0, {8'h00, 8'h00, 8'h00},             4'b0000, 0, 0, 16'h1E00};
    table_v[3] = '{"early_stop", 8'h34, 1, {8'h00, 8'h00, {PDOWN, 1'b0}},     4'b0011, 0, 1, 16'h1E00};
    table_v[4] = '{"extra_byte", 8'h34, 3, {8'h34, 8'h12, 8'h08},             4'b0111, 0, 1, 16'h1E00};

    cyc(3);
    #1;
    check("rst_sda_oe", bus.SDA_OE, 0);
    check("rst_data",   bus.DATA,   16'h0000);
    check("rst_valid",  bus.VALID,  0);
    check("rst_busy",   bus.BUSY,   0);
    check("rst_error",  bus.ERROR,  0);
    rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 5; i++) run_txn(table_v[i]);
    ref_data = 16'h1E00;

    // Repeated START after four bits of byte 2, then a complete ACTIVE=1 write.
    valid_cnt = 0; err_cnt = 0;
    do_start();
    send_byte(8'h34); ack_bit(a);
    send_byte(8'hAB); ack_bit(a);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    do_start();
    #1;
    check("restart_error", err_cnt,   1);
    check("restart_valid", valid_cnt, 0);
    check("restart_busy",  bus.BUSY,  1);
    send_byte(8'h34);             ack_bit(a); acks3[0] = a;
    send_byte({ACTIVE, 1'b0});    ack_bit(a); acks3[1] = a;
    send_byte(8'h01);             ack_bit(a); acks3[2] = a;
    do_stop();
    #1;
    ref_data = 16'h1201;
    check("restart_acks",   acks3,     3'b111);
    check("restart_commit", valid_cnt, 1);
    check("restart_data",   bus.DATA,  ref_data);
    check("restart_err_tot", err_cnt,  1);

    // Reset while the responder is holding the byte-1 ACK low.
    do_start();
    send_byte(8'h34); ack_bit(a);
    send_byte({LHPOUT, 1'b0});
    cyc(HALF/2);
    #1;
    check("ack1_held", bus.SDA_OE, 1);
    check("ack1_busy", bus.BUSY,   1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sda_oe", bus.SDA_OE, 0);
    check("rst_mid_busy",   bus.BUSY,   0);
    check("rst_mid_data",   bus.DATA,   16'h0000);
    sda_m = 1'b1;
    scl_m = 1'b1;
    cyc(3);
    #1 rst_n = 1'b1;
    cyc(HALF);
    ref_data = 16'h0000;
    v = '{"after_rst", 8'h34, 2, {8'h00, 8'h97, {LHPOUT, 1'b0}}, 4'b0, 0, 0, 16'h0};
    v = model(v);
    run_txn(v);
    check("after_rst_word", bus.DATA, 16'h0497);

    for (int n = 0; n < 20; n++) begin
      int kind;
      kind     = $urandom_range(0, 3);
      v.name   = $sformatf("rand%0d", n);
      v.addr   = (kind < 2) ? 8'h34 : (kind == 2) ? 8'h35 : 8'($urandom);
      v.nb     = $urandom_range(0, 3);
      v.bytes  = 24'($urandom);
      v = model(v);
      run_txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wm8731_iic_responder.md
Name: wm8731_iic_responder

Overview:
- I2C write-only target (responder) that models the WM8731 control port on the codec side of AUD_SCLK/AUD_SDAT.
- Oversamples SCL/SDA on MCLK and decodes START, device address, two data bytes and STOP.
- Drives ACK open-drain and presents each completed 16-bit control word (7-bit register address plus 9-bit value) with a one-cycle VALID strobe.
- Used as the bench/loopback partner for the codec configuration master and as a register-write monitor on FPGA.

Parameters:
- DEV_ADDR, 7'b0011010, 7-bit device address that is ACKed.
- MIN_HALF, 8, minimum SCL high/low time in MCLK cycles guaranteed by the master (documentation/assertion only).

Ports:
- MCLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-low reset.
- SCL_IN  input  1  I2C clock from bus, asynchronous to MCLK.
- SDA_IN  input  1  I2C data from bus, asynchronous.
- SDA_OE  output  1  1 = pull SDA low (ACK); 0 = release. Pad: AUD_SDAT = SDA_OE ? 0 : z.
- DATA  output  16  last received word {byte1, byte2}; [15:9] register address, [8:0] value.
- VALID  output  1  one-cycle strobe; DATA is new.
- BUSY  output  1  high from START to STOP/abort.
- ERROR  output  1  one-cycle strobe on protocol violation.

Behaviour:
- Reset values: SDA_OE=0, DATA=16'h0000, VALID=0, BUSY=0, ERROR=0, state IDLE, shift register 0, bit count 0, synchronizers 1.
- Input path: 2-flop synchronizer on each line, then a previous-value register.
  - Internal scl_rise/scl_fall/sda_rise/sda_fall events occur 3 MCLK after a pin change.
- START: sda_fall while synced SCL=1. STOP: sda_rise while synced SCL=1. Both are detected in every state.
- Data bits are sampled MSB first on scl_rise. The bit counter is 3 bits and wraps 7→0 at the end of each byte.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP, IGNORE.
- IDLE → ADDR on START; BUSY=1, bit counter cleared.
- ADDR: after 8 bits, the first 7 bits are compared with DEV_ADDR and bit 8 is R/W.
  - Match and R/W=0 → ACK_A.
  - Otherwise → IGNORE (no ACK).
- ACK_x entry: on the scl_fall that ends bit 8, SDA_OE=1.
  - SDA_OE is held through the 9th SCL high and released on the following scl_fall.
  - Then ACK_A→BYTE1, ACK_1→BYTE2, ACK_2→WAIT_STOP.
- BYTE1 bits go to a staging register [15:8]; BYTE2 bits go to [7:0]. DATA is not updated until commit.
- WAIT_STOP + STOP: DATA←staging, VALID=1 for exactly 1 cycle (1 cycle after STOP detect), BUSY=0, → IDLE.
- WAIT_STOP + further bits: byte is not ACKed, state → IGNORE, ERROR=1 at the subsequent STOP. No commit.
- STOP in any state other than IDLE/WAIT_STOP/IGNORE: ERROR=1, no commit, SDA_OE=0, → IDLE.
- IGNORE + STOP: → IDLE, no ERROR.
- START (repeated) in any non-IDLE state:
  - ERROR=1 if mid-transfer (ADDR excluded).
  - Staging is discarded, SDA_OE=0, → ADDR.
- Simultaneous VALID/ERROR is impossible by construction. START and STOP can never coincide on the same cycle (SDA has one edge).
- Reset mid-transfer: immediate return to reset values; the bus is released within the same cycle (asynchronous clear of SDA_OE).

Optional Feature:
- Macro IIC_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows each synchronizer.
  - Pulses ≤1 MCLK are rejected.
  - Pin-to-event latency becomes 5 MCLK.
- Undefined: filter absent, 3 MCLK latency, single-cycle glitches are seen as edges.

Decomposition:
- Shared package wm8731_pkg:
  - State enum.
  - WM8731_DEV_ADDR = 7'b0011010.
  - Register address constants (LLINE=0 … ACTIVE=9, RESET_REG=15).
  - Word field widths (REG_W=7, VAL_W=9).
- Sub-module iic_line_sync: synchronizer, optional filter and edge detect, instantiated once per line.

Test Plan:
- Write dev 0x1A, word 16'h1E00 (reset reg), STOP → ACK on all three 9th clocks; VALID one cycle with DATA=16'h1E00; BUSY falls.
- Address 0x1B, write → no ACK (SDA_OE stays 0), IGNORE; STOP → no VALID, no ERROR, DATA unchanged.
- Address 0x1A with R/W=1 → no ACK; STOP → no VALID.
- Word 16'h0C00, STOP after byte1 ACK → ERROR pulse, no VALID, DATA keeps previous 16'h1E00.
- Repeated START after 4 bits of byte2, then full transfer of 16'h1201 → ERROR pulse at the START; then VALID with DATA=16'h1201.
- Assert RESET during the ACK_1 low phase → SDA_OE=0 and BUSY=0 in the same cycle; the next full transfer of 16'h0497 completes normally.
